bnn_layer_sched: RTL and testbench

BNN_LAYER_SCHED -- requirements
Module: bnn_layer_sched

---
 rtl/bnn_layer_sched.sv | 142 ++++++++++++++
 tb/tb_bnn_layer_sched.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bnn_layer_sched.sv
// Layer sequencer for the keyword/VAD BNN: gathers MFCC frames, walks conv1..fc2
// through the datapath, turns the final scores into a speech decision and tracks sustained speech.
module bnn_layer_sched #(
  parameter int N_FRAMES = 8,
  parameter int TIMEOUT  = 1023,
  parameter int HOLD     = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mfcc_wr_en,
  input  logic       frame_valid,
  output logic       layer_start,
  output logic [2:0] layer_sel,
  input  logic       layer_done,
  input  logic [7:0] score0,
  input  logic [7:0] score1,
  output logic       busy,
  output logic [1:0] result,
  output logic       result_valid,
  output logic       vad_duration,
  output logic       timeout_err,
  output logic       overrun_err,
  input  logic       err_clr
);

  typedef enum logic [2:0] {IDLE, COLLECT, START, WAIT, DECIDE} state_t;

  localparam logic [7:0]  FRAME_LAST   = 8'(N_FRAMES - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);
  localparam logic [3:0]  HOLD_CNT     = 4'(HOLD);
  localparam logic [2:0]  LAST_LAYER   = 3'd4;

  state_t            state;
  logic [7:0]        frame_cnt;
  logic [15:0]       tmo_cnt;
  logic [3:0]        speech_cnt;
  logic signed [7:0] score0_p0;
  logic signed [7:0] score1_p0;
  logic [1:0]        decision;

  function automatic logic [1:0] decide(input logic signed [7:0] s0,
                                        input logic signed [7:0] s1);
    if (s1 > s0)      return 2'b01;
    else if (s0 > s1) return 2'b10;
    else              return 2'b00;
  endfunction

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  assign busy     = (state != IDLE);
  assign decision = decide(score0_p0, score1_p0);

  // Stage p0: fc2 scores captured on the final layer_done (data path, no reset)
  always_ff @(posedge clk) begin
    if (state == WAIT && layer_done && layer_sel == LAST_LAYER) begin
      score0_p0 <= signed'(score0);
      score1_p0 <= signed'(score1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      frame_cnt    <= 8'd0;
      tmo_cnt      <= 16'd0;
      speech_cnt   <= 4'd0;
      layer_sel    <= 3'd0;
      layer_start  <= 1'b0;
      result       <= 2'b00;
      result_valid <= 1'b0;
      vad_duration <= 1'b0;
      timeout_err  <= 1'b0;
      overrun_err  <= 1'b0;
    end else begin
      layer_start  <= 1'b0;
      result_valid <= 1'b0;
      vad_duration <= (speech_cnt >= HOLD_CNT);

      // Later assignments win, so a same-cycle error event beats err_clr.
      if (err_clr) begin
        timeout_err <= 1'b0;
        overrun_err <= 1'b0;
      end
      if (frame_valid && (state == START || state == WAIT || state == DECIDE))
        overrun_err <= 1'b1;

      case (state)
        IDLE: begin
          if (mfcc_wr_en) begin
            state     <= COLLECT;
            frame_cnt <= 8'd0;
          end
        end
        COLLECT: begin
          if (!mfcc_wr_en) begin
            state <= IDLE;
          end else if (frame_valid) begin
            frame_cnt <= frame_cnt + 8'd1;
            if (frame_cnt == FRAME_LAST) begin
              state       <= START;
              layer_sel   <= 3'd0;
              layer_start <= 1'b1;
            end
          end
        end
        START: begin
          state   <= WAIT;
          tmo_cnt <= 16'd0;
        end
        WAIT: begin
          if (layer_done) begin
            if (layer_sel == LAST_LAYER) begin
              state <= DECIDE;
            end else begin
              layer_sel   <= layer_sel + 3'd1;
              layer_start <= 1'b1;
              state       <= START;
            end
          end else if (tmo_cnt == TIMEOUT_LAST) begin
            timeout_err <= 1'b1;
            layer_sel   <= 3'd0;
            state       <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        DECIDE: begin
          result       <= decision;
          result_valid <= 1'b1;
          speech_cnt   <= (decision == 2'b01) ? sat_inc4(speech_cnt) : 4'd0;
          layer_sel    <= 3'd0;
          frame_cnt    <= 8'd0;
          state        <= mfcc_wr_en ? COLLECT : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bnn_layer_sched.sv
// Scoreboard bench for bnn_layer_sched: randomized inferences plus error, reset and enable-drop scenarios.
module tb_bnn_layer_sched;

  localparam int N_FRAMES = 8;
  localparam int TIMEOUT  = 40;
  localparam int HOLD     = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mfcc_wr_en = 1'b0;
  logic       frame_valid = 1'b0;
  logic       layer_done;
  logic       err_clr = 1'b0;
  logic [7:0] score0 = 8'd0;
  logic [7:0] score1 = 8'd0;
  logic       layer_start, busy, result_valid, vad_duration, timeout_err, overrun_err;
  logic [2:0] layer_sel;
  logic [1:0] result;

  bnn_layer_sched #(.N_FRAMES(N_FRAMES), .TIMEOUT(TIMEOUT), .HOLD(HOLD)) dut (
    .clk(clk), .rst(rst), .mfcc_wr_en(mfcc_wr_en), .frame_valid(frame_valid),
    .layer_start(layer_start), .layer_sel(layer_sel), .layer_done(layer_done),
    .score0(score0), .score1(score1), .busy(busy), .result(result),
    .result_valid(result_valid), .vad_duration(vad_duration),
    .timeout_err(timeout_err), .overrun_err(overrun_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] res;
    logic       vad;
  } res_t;

  int   exp_sel[$];
  res_t exp_res[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_starts = 0;
  int   stray_cnt = 0;
  int   withhold_sel = -1;
  int   fixed_delay = 0;
  int   streak = 0;
  logic [1:0] last_res = 2'b00;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int outs_vec();
    return int'({layer_start, layer_sel, busy, result, result_valid,
                 vad_duration, timeout_err, overrun_err});
  endfunction

  // Reference model: one inference = five layers in order, then a signed score compare.
  task automatic expect_inf(input byte s0, input byte s1);
    logic [1:0] r;
    res_t e;
    for (int i = 0; i < 5; i++) exp_sel.push_back(i);
    score0 = s0;
    score1 = s1;
    r = (s1 > s0) ? 2'b01 : ((s0 > s1) ? 2'b10 : 2'b00);
    streak = (r == 2'b01) ? ((streak < 15) ? streak + 1 : 15) : 0;
    e.res = r;
    e.vad = (streak >= HOLD);
    exp_res.push_back(e);
    last_res = r;
  endtask

  task automatic send_frames(input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      frame_valid = 1'b1;
      tick();
      frame_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_sel.size() != 0 || exp_res.size() != 0) && t < 2000) begin
      tick();
      t++;
    end
    chk("drain", exp_sel.size() + exp_res.size(), 0);
    if (t >= 2000) begin
      exp_sel.delete();
      exp_res.delete();
    end
    repeat (3) tick();
  endtask

  task automatic wait_starts(input int target);
    int t = 0;
    while (n_starts < target && t < 500) begin
      tick();
      t++;
    end
    chk("start_wait", (n_starts >= target) ? 1 : 0, 1);
  endtask

  // Datapath stand-in: answers each layer_start with a layer_done after a delay.
  initial begin : responder
    int stray_seen;
    int d;
    stray_seen = 0;
    layer_done = 1'b0;
    forever begin
      @(negedge clk);
      if (stray_cnt != stray_seen) begin
        stray_seen = stray_cnt;
        @(posedge clk); #1 layer_done = 1'b1;
        @(posedge clk); #1 layer_done = 1'b0;
      end else if (layer_start && int'(layer_sel) != withhold_sel) begin
        d = (fixed_delay > 0) ? fixed_delay : int'($urandom_range(1, 6));
        repeat (d) @(posedge clk);
        #1 layer_done = 1'b1;
        @(posedge clk); #1 layer_done = 1'b0;
      end
    end
  end

  initial begin : monitor
    logic done_prev;
    logic busy_prev;
    int   sel_prev;
    res_t e;
    done_prev = 1'b0;
    busy_prev = 1'b0;
    sel_prev  = 0;
    forever begin
      @(negedge clk);
      if (done_prev && busy_prev && sel_prev < 4)
        chk("done_to_start_latency", int'(layer_start), 1);
      done_prev = layer_done;
      busy_prev = busy;
      sel_prev  = int'(layer_sel);
      if (layer_start) begin
        n_starts++;
        chk("start_while_busy", int'(busy), 1);
        chk("start_expected", (exp_sel.size() > 0) ? 1 : 0, 1);
        if (exp_sel.size() > 0) chk("layer_sel", int'(layer_sel), exp_sel.pop_front());
      end
      if (result_valid) begin
        chk("result_valid_expected", (exp_res.size() > 0) ? 1 : 0, 1);
        if (exp_res.size() > 0) begin
          e = exp_res.pop_front();
          chk("result", int'(result), int'(e.res));
          @(negedge clk);
          chk("result_valid_one_cycle", int'(result_valid), 0);
          chk("vad_duration", int'(vad_duration), int'(e.vad));
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "simulation did not finish");
  end

  initial begin : stim
    int  base;
    byte s0, s1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", outs_vec(), 0);
    rst = 1'b0;
    tick();
    chk("idle_after_reset", int'(busy), 0);

    // Baseline inference with fixed datapath latency
    mfcc_wr_en = 1'b1;
    tick(); tick();
    fixed_delay = 5;
    expect_inf(-5, 20);
    send_frames(N_FRAMES);
    drain();
    chk("first_result", int'(result), 1);
    fixed_delay = 0;

    // Sustained speech, then a tie
    expect_inf(-30, 10); send_frames(N_FRAMES); drain();
    expect_inf(0, 1);    send_frames(N_FRAMES); drain();
    chk("vad_after_three", int'(vad_duration), 1);
    expect_inf(7, 7);    send_frames(N_FRAMES); drain();
    chk("tie_result", int'(result), 0);
    chk("vad_after_tie", int'(vad_duration), 0);

    for (int k = 0; k < 12; k++) begin
      s0 = byte'($urandom);
      s1 = ($urandom_range(0, 3) == 0) ? s0 : byte'($urandom);
      if (k == 0) begin s0 = -128; s1 = 127;  end
      if (k == 1) begin s0 = 127;  s1 = -128; end
      if (k == 2) begin s0 = -1;   s1 = 0;    end
      expect_inf(s0, s1);
      send_frames(N_FRAMES);
      drain();
    end

    // Frame arriving while layers run
    chk("overrun_clear_before", int'(overrun_err), 0);
    base = n_starts;
    expect_inf(byte'($urandom), byte'($urandom));
    send_frames(N_FRAMES);
    wait_starts(base + 1);
    frame_valid = 1'b1; tick(); frame_valid = 1'b0;
    chk("overrun_set", int'(overrun_err), 1);
    frame_valid = 1'b1; err_clr = 1'b1; tick(); frame_valid = 1'b0; err_clr = 1'b0;
    chk("overrun_set_beats_clr", int'(overrun_err), 1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("overrun_clr", int'(overrun_err), 0);
    drain();

    // Layer timeout at conv3
    chk("timeout_clear_before", int'(timeout_err), 0);
    withhold_sel = 2;
    base = n_starts;
    for (int i = 0; i < 3; i++) exp_sel.push_back(i);
    send_frames(N_FRAMES);
    wait_starts(base + 3);
    mfcc_wr_en = 1'b0;
    repeat (TIMEOUT - 3) tick();
    chk("timeout_not_early", int'(timeout_err), 0);
    repeat (6) tick();
    chk("timeout_set", int'(timeout_err), 1);
    chk("timeout_idle", int'(busy), 0);
    chk("timeout_sel0", int'(layer_sel), 0);
    chk("timeout_result_kept", int'(result), int'(last_res));
    withhold_sel = -1;
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("timeout_clr", int'(timeout_err), 0);

    // Reset in WAIT at fc1
    mfcc_wr_en = 1'b1;
    tick(); tick();
    withhold_sel = 3;
    base = n_starts;
    for (int i = 0; i < 4; i++) exp_sel.push_back(i);
    send_frames(N_FRAMES);
    wait_starts(base + 4);
    mfcc_wr_en = 1'b0;
    tick();
    chk("pre_reset_sel", int'(layer_sel), 3);
    rst = 1'b1;
    #1;
    chk("reset_mid_wait", outs_vec(), 0);
    streak = 0;
    last_res = 2'b00;
    tick();
    rst = 1'b0;
    stray_cnt++;
    repeat (6) tick();
    chk("stray_done_busy", int'(busy), 0);
    chk("stray_done_outputs", outs_vec(), 0);
    withhold_sel = -1;

    // Enable dropped mid-collection, then restart from zero
    mfcc_wr_en = 1'b1;
    tick(); tick();
    send_frames(4);
    mfcc_wr_en = 1'b0;
    repeat (3) tick();
    chk("drop_idle", int'(busy), 0);
    base = n_starts;
    mfcc_wr_en = 1'b1;
    tick(); tick();
    send_frames(N_FRAMES - 1);
    repeat (5) tick();
    chk("restart_no_start", n_starts, base);
    chk("restart_busy", int'(busy), 1);
    expect_inf(byte'($urandom), byte'($urandom));
    send_frames(1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
